// File: rtl/math_pipelined_downcounter_pkg.sv
// Chunk geometry shared by the chunked counter and the pipelined ALU:
// how a WIDTH-bit value is split into pipeline chunks.
package math_pipelined_downcounter_pkg;

    function automatic int alu_width(input int width, input int latency);
        return (latency <= 1) ? width : (width + latency - 1) / latency;
    endfunction

    function automatic int chunk_count(input int width, input int latency);
        int aw;
        aw = alu_width(width, latency);
        return (width + aw - 1) / aw;
    endfunction

    function automatic int last_chunk_size(input int width, input int latency);
        return width - (chunk_count(width, latency) - 1) * alu_width(width, latency);
    endfunction

endpackage

// File: rtl/math_downcounter_chunk.sv
// One SIZE-bit slice of the chunked down-counter: loads its slice, decrements on
// dec_in and registers a borrow for the next chunk when it passes through zero.
module math_downcounter_chunk #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [SIZE-1:0] load_slice,
    input  logic            dec_in,
    output logic [SIZE-1:0] value,
    output logic            borrow_out,
    output logic            is_zero
);

    logic [SIZE-1:0] value_d, value_q;
    logic            borrow_d, borrow_q;
    logic            zero_d, zero_q;

    always_comb begin
        value_d  = value_q;
        borrow_d = 1'b0;
        if (load) begin
            value_d = load_slice;
        end else if (dec_in) begin
            value_d  = value_q - SIZE'(1);
            borrow_d = (value_q == '0);
        end
        zero_d = (value_d == '0);
    end

    // zero flag clears on reset so the top-level zero only asserts once a
    // post-reset cycle has actually observed a zero count.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q  <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            value_q  <= value_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign value      = value_q;
    assign borrow_out = borrow_q;
    assign is_zero    = zero_q;

endmodule

// File: rtl/math_pipelined_downcounter.sv
// Loadable WIDTH-bit down-counter built from chunks with registered borrows;
// upper chunks lag by one cycle per chunk and settled marks an exact count.
module math_pipelined_downcounter
    import math_pipelined_downcounter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             settled,
    output logic             zero,
    output logic             wrap
);

    localparam int AW   = alu_width(WIDTH, LATENCY);
    localparam int CC   = chunk_count(WIDTH, LATENCY);
    localparam int LAST = last_chunk_size(WIDTH, LATENCY);

    logic [CC-1:0] borrow;
    logic [CC-1:0] is_zero;
    logic [CC-1:0] dec;
    logic          settled_d;
    logic          zero_d, zero_q;

    for (genvar i = 0; i < CC; i++) begin : g_chunk
        localparam int SZ = (i == CC - 1) ? LAST : AW;
        localparam int LO = i * AW;

        if (i == 0) begin : g_dec0
            assign dec[i] = enable;
        end else begin : g_deci
            assign dec[i] = borrow[i-1];
        end

        math_downcounter_chunk #(.SIZE(SZ)) u_chunk (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_slice (load_value[LO+:SZ]),
            .dec_in     (dec[i]),
            .value      (count[LO+:SZ]),
            .borrow_out (borrow[i]),
            .is_zero    (is_zero[i])
        );
    end

    // Next borrow of chunk i is dec[i] & (chunk i currently zero) unless loading,
    // so next-settled comes straight from registered flags.
    if (CC == 1) begin : g_single
        assign settled   = 1'b1;
        assign settled_d = 1'b1;
    end else begin : g_multi
        assign settled   = ~|borrow[CC-2:0];
        assign settled_d = load | ~|(dec[CC-2:0] & is_zero[CC-2:0]);
    end

    always_comb begin
        zero_d = &is_zero & settled_d;
    end

    always_ff @(posedge clk) begin
        if (rst) zero_q <= 1'b0;
        else     zero_q <= zero_d;
    end

    assign zero = zero_q;
    assign wrap = borrow[CC-1];

endmodule

// File: tb/tb_math_pipelined_downcounter.sv
// Scoreboard bench: directed vectors push hand-computed expectations tagged with
// the cycle they are due; a negedge monitor pops and compares.
module tb_math_pipelined_downcounter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_a, en_a;
    logic [7:0] lv_a, cnt_a;
    logic       set_a, zero_a, wrap_a;
    logic       ld_b, en_b;
    logic [9:0] lv_b, cnt_b;
    logic       set_b, zero_b, wrap_b;

    always #5 clk = ~clk;

    math_pipelined_downcounter #(.WIDTH(8), .LATENCY(2)) u_dut_a (
        .clk(clk), .rst(rst), .load(ld_a), .load_value(lv_a), .enable(en_a),
        .count(cnt_a), .settled(set_a), .zero(zero_a), .wrap(wrap_a)
    );

    math_pipelined_downcounter #(.WIDTH(10), .LATENCY(4)) u_dut_b (
        .clk(clk), .rst(rst), .load(ld_b), .load_value(lv_b), .enable(en_b),
        .count(cnt_b), .settled(set_b), .zero(zero_b), .wrap(wrap_b)
    );

    typedef struct {
        int         due;
        bit         on_b;
        int         tag;
        logic [9:0] cnt;
        logic       s, z, w;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    exp_t       mon_e;
    logic [9:0] act_c;
    logic       act_s, act_z, act_w;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            act_c = mon_e.on_b ? cnt_b  : {2'b00, cnt_a};
            act_s = mon_e.on_b ? set_b  : set_a;
            act_z = mon_e.on_b ? zero_b : zero_a;
            act_w = mon_e.on_b ? wrap_b : wrap_a;
            n_tests++;
            if (mon_e.due != cyc || act_c !== mon_e.cnt || act_s !== mon_e.s ||
                act_z !== mon_e.z || act_w !== mon_e.w) begin
                n_fail++;
                $display("FAIL %s%0d (cycle %0d): count=%h settled=%b zero=%b wrap=%b, expected count=%h settled=%b zero=%b wrap=%b",
                         mon_e.on_b ? "B" : "A", mon_e.tag, cyc, act_c, act_s, act_z, act_w,
                         mon_e.cnt, mon_e.s, mon_e.z, mon_e.w);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expectation for the state right after the next clock edge.
    task automatic expect_out(input bit on_b, input int tag, input logic [9:0] c,
                              input logic s, input logic z, input logic w);
        exp_t e;
        e.due = cyc + 1; e.on_b = on_b; e.tag = tag;
        e.cnt = c; e.s = s; e.z = z; e.w = w;
        sb.push_back(e);
    endtask

    task automatic a_step(input logic r, input logic l, input logic [7:0] v, input logic e,
                          input int tag, input logic [7:0] c, input logic s,
                          input logic z, input logic w);
        rst = r; ld_a = l; lv_a = v; en_a = e;
        expect_out(1'b0, tag, {2'b00, c}, s, z, w);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ld_a = 1'b0; en_a = 1'b0; lv_a = '0;
        ld_b = 1'b0; en_b = 1'b0; lv_b = '0;
        tick();
        tick();

        // Reset state on both instances.
        expect_out(1'b1, 0, 10'h000, 1'b1, 1'b0, 1'b0);
        a_step(1, 0, 8'h00, 0,  0, 8'h00, 1, 0, 0);

        // Load 0x10, one decrement: borrow ripples into the upper chunk.
        a_step(0, 1, 8'h10, 0,  1, 8'h10, 1, 0, 0);
        a_step(0, 0, 8'h00, 1,  2, 8'h1F, 0, 0, 0);
        a_step(0, 0, 8'h00, 0,  3, 8'h0F, 1, 0, 0);
        a_step(0, 0, 8'h00, 0,  4, 8'h0F, 1, 0, 0);

        // Load 0x01, decrement to zero: zero rises one cycle later.
        a_step(0, 1, 8'h01, 0,  5, 8'h01, 1, 0, 0);
        a_step(0, 0, 8'h00, 1,  6, 8'h00, 1, 0, 0);
        a_step(0, 0, 8'h00, 0,  7, 8'h00, 1, 1, 0);

        // Load 0x00, decrement through zero: single wrap pulse, zero falls.
        a_step(0, 1, 8'h00, 0,  8, 8'h00, 1, 1, 0);
        a_step(0, 0, 8'h00, 1,  9, 8'h0F, 0, 0, 0);
        a_step(0, 0, 8'h00, 0, 10, 8'hFF, 1, 0, 1);
        a_step(0, 0, 8'h00, 0, 11, 8'hFF, 1, 0, 0);

        // Load with enable while a borrow is in flight: load wins.
        a_step(0, 1, 8'h10, 0, 12, 8'h10, 1, 0, 0);
        a_step(0, 0, 8'h00, 1, 13, 8'h1F, 0, 0, 0);
        a_step(0, 1, 8'h20, 1, 14, 8'h20, 1, 0, 0);
        a_step(0, 0, 8'h00, 0, 15, 8'h20, 1, 0, 0);

        // Reset while chunk 0 is borrowing, then reload.
        a_step(0, 1, 8'h00, 0, 16, 8'h00, 1, 0, 0);
        a_step(0, 0, 8'h00, 1, 17, 8'h0F, 0, 0, 0);
        a_step(1, 0, 8'h00, 0, 18, 8'h00, 1, 0, 0);
        a_step(0, 1, 8'h05, 0, 19, 8'h05, 1, 0, 0);
        a_step(0, 0, 8'h00, 0, 20, 8'h05, 1, 0, 0);

        // 10-bit, chunks 3/3/3/1: count 0x200 down to zero continuously.
        rst = 1'b1; ld_a = 1'b0; en_a = 1'b0;
        expect_out(1'b1, 1, 10'h000, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b0; ld_b = 1'b1; lv_b = 10'h200;
        expect_out(1'b1, 2, 10'h200, 1'b1, 1'b0, 1'b0);
        tick();
        ld_b = 1'b0; en_b = 1'b1;
        repeat (512) tick();
        en_b = 1'b0;
        repeat (5) tick();
        expect_out(1'b1, 3, 10'h000, 1'b1, 1'b1, 1'b0);
        tick();

        // One more decrement from zero: borrow crosses all four chunks.
        en_b = 1'b1;
        expect_out(1'b1, 4, 10'h007, 1'b0, 1'b0, 1'b0);
        tick();
        en_b = 1'b0;
        expect_out(1'b1, 5, 10'h03F, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out(1'b1, 6, 10'h1FF, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out(1'b1, 7, 10'h3FF, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out(1'b1, 8, 10'h3FF, 1'b1, 1'b0, 1'b0);
        tick();

        tick();
        tick();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/math_pipelined_downcounter.md
Name: math_pipelined_downcounter

Overview:
- Loadable down-counter for WIDTH-bit values, split into chunks with a registered borrow between chunks. Any timing path covers at most one chunk (≈WIDTH/LATENCY bits).
- It is the decrementing counterpart of the chunked carry-chain adder. It feeds timers and terminal-count logic in the same toolbox.
- Upper chunks lag lower chunks by one cycle per chunk. A `settled` flag marks when `count` is exact.

Parameters:
- WIDTH, 16, counter width in bits (≥1).
- LATENCY, 4, maximum chunk count. 0 or 1 gives a single-chunk, non-pipelined counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- load  input  1  load load_value; has priority over enable.
- load_value  input  WIDTH  value loaded on load.
- enable  input  1  decrement request for chunk 0.
- count  output  WIDTH  current counter value; exact only while settled=1.
- settled  output  1  1 when no borrow is in flight.
- zero  output  1  registered: count==0 and settled.
- wrap  output  1  one-cycle pulse after the top chunk borrows (counter passed 0 → all ones).

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On rst: count=0, all borrow registers=0, settled=1, zero=0, wrap=0. rst overrides load and enable.
- Chunking constants:
  - ALU_WIDTH = ceil(WIDTH/LATENCY), or WIDTH when LATENCY ≤ 1.
  - CHUNK_COUNT = ceil(WIDTH/ALU_WIDTH).
  - LAST_CHUNK_SIZE = WIDTH − (CHUNK_COUNT−1)·ALU_WIDTH.
- Per-chunk registers c[i] and borrow flags b[i], for i = 0..CHUNK_COUNT−1.
- Load cycle: every c[i] takes its slice of load_value, every b[i] clears, wrap=0. Any in-flight borrow is discarded.
- Chunk 0: if enable and not load, c[0] ← c[0]−1 mod 2^ALU_WIDTH, and b[0] ← (c[0]==0). Otherwise b[0] ← 0.
- Chunk i > 0: if b[i−1] and not load, c[i] ← c[i]−1 mod 2^size, and b[i] ← (c[i]==0). Otherwise b[i] ← 0.
- Borrow propagation is independent of enable: in-flight borrows always ripple to completion.
- wrap = b[CHUNK_COUNT−1]. The top borrow has no destination chunk and is reported only as the wrap pulse.
- settled = ~|b[CHUNK_COUNT−2:0], combinational from registers. It is constant 1 when CHUNK_COUNT = 1.
- Per-chunk zero flags z[i] are registered with c[i] and equal (next c[i] == 0).
- zero register ← &z & (next settled). zero asserts the cycle after count becomes exactly 0 with nothing in flight.
- Latency:
  - load → count valid: 1 cycle.
  - enable → chunk 0 updated: 1 cycle.
  - Worst-case settle after a decrement: CHUNK_COUNT cycles.
- Continuous enable: decrementing every cycle is legal. Borrows pipeline and count is eventually exact, but settled may stay low while successive decrements keep borrows in flight.
- Simultaneous load and enable: load wins and the decrement is dropped.
- Reset mid-borrow: all borrows are lost; count=0.
- Non-power-of-two widths: the last chunk is LAST_CHUNK_SIZE wide and wraps modulo 2^LAST_CHUNK_SIZE.

Decomposition:
- Chunk geometry functions (ALU_WIDTH, CHUNK_COUNT, LAST_CHUNK_SIZE) go in the shared toolbox include beside the recursion iterators. They are common with the pipelined ALU.
- One sub-module is natural: math_downcounter_chunk, parameterised by SIZE. Ports: clk, rst, load, load_slice, dec_in, value, borrow_out, is_zero. It is instantiated once per chunk in a generate loop.

Test Plan:
- WIDTH=8, LATENCY=2. Load 0x10, then enable for 1 cycle → count 0x1F with settled=0 for 1 cycle, then 0x0F with settled=1; zero=0; wrap never pulses.
- WIDTH=8, LATENCY=2. Load 0x01, then enable for 1 cycle → count 0x00, settled=1, and zero=1 on the following cycle.
- WIDTH=8, LATENCY=2. Load 0x00, then enable for 1 cycle → count 0x0F, then 0xFF; wrap pulses high for exactly 1 cycle, 2 cycles after enable; zero falls.
- WIDTH=10, LATENCY=4 (chunks 3,3,3,1). Load 0x200, then enable continuously for 512 cycles → after settling count=0x000 and zero=1. The scoreboard compares against a reference value delayed to the settle point.
- Load 0x20 in the same cycle as enable while a borrow is in flight → count=0x20, settled=1 on the next cycle, and no decrement occurs.
- Assert rst while b[0]=1 → the next cycle has count=0, settled=1, wrap=0, zero=0. After release, load 0x05 → count=0x05.
